// File: rtl/select_in_if.sv
// Handshake bundle for select_in: index load, upstream enqueue and per-channel
// dequeue/head signals.
interface select_in_if #(
  parameter int unsigned funnelWidth = 8,
  parameter int unsigned width       = 16
);
  logic                         select_ena;
  logic [31:0]                  select_v;
  logic                         select_rdy;
  logic                         enq_ena;
  logic [width-1:0]             enq_v;
  logic                         enq_rdy;
  logic [funnelWidth*width-1:0] out_first;
  logic [funnelWidth-1:0]       out_first_rdy;
  logic [funnelWidth-1:0]       out_deq_ena;
  logic [funnelWidth-1:0]       out_deq_rdy;
  logic                         busy;

  modport master (
    output select_ena, select_v, enq_ena, enq_v, out_deq_ena,
    input  select_rdy, enq_rdy, out_first, out_first_rdy, out_deq_rdy, busy
  );

  modport slave (
    input  select_ena, select_v, enq_ena, enq_v, out_deq_ena,
    output select_rdy, enq_rdy, out_first, out_first_rdy, out_deq_rdy, busy
  );
endinterface

// File: rtl/select_in.sv
// Single-input funnel: routes each upstream item to the channel chosen by a
// loadable index; every channel holds one item in its own one-entry buffer.
module select_in #(
  parameter int unsigned funnelWidth = 8,
  parameter int unsigned width       = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  select_in_if.slave  bus
);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NCH_MAX = 16;
  localparam int unsigned CMP_W   = IDX_W + 1;

  logic [IDX_W-1:0]       index_q;
  logic [funnelWidth-1:0] full_q;
  logic [width-1:0]       data_q [funnelWidth];

  logic [NCH_MAX-1:0] full_pad_c;
  logic [NCH_MAX-1:0] deq_pad_c;
  logic               idx_ok_c;
  logic               enq_rdy_c;
  logic               enq_fire_c;
  logic               unused_select_hi;

  // Pad per-channel vectors to the full 4-bit index range so an out-of-range
  // index never selects past the end.
  always_comb begin
    full_pad_c = NCH_MAX'(full_q);
    deq_pad_c  = NCH_MAX'(bus.out_deq_ena);
    idx_ok_c   = CMP_W'(index_q) < CMP_W'(funnelWidth);
    enq_rdy_c  = idx_ok_c && (!full_pad_c[index_q] || deq_pad_c[index_q]);
    enq_fire_c = bus.enq_ena && enq_rdy_c;
  end

  assign unused_select_hi = ^bus.select_v[31:IDX_W];

  // Index register; a same-cycle enqueue still routes by the old value.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      index_q <= '0;
    end else if (bus.select_ena) begin
      index_q <= bus.select_v[IDX_W-1:0];
    end
  end

  // Per-channel buffers; refill wins over dequeue so a simultaneous
  // deq+enq keeps the channel full with the new item.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_q <= '0;
      for (int i = 0; i < int'(funnelWidth); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(funnelWidth); i++) begin
        if (enq_fire_c && (index_q == IDX_W'(i))) begin
          data_q[i] <= bus.enq_v;
          full_q[i] <= 1'b1;
        end else if (bus.out_deq_ena[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(funnelWidth); g++) begin : g_head
    assign bus.out_first[g*width +: width] = data_q[g];
  end

  assign bus.select_rdy    = 1'b1;
  assign bus.enq_rdy       = enq_rdy_c;
  assign bus.out_first_rdy = full_q;
  assign bus.out_deq_rdy   = full_q;
  assign bus.busy          = |full_q;
endmodule

// File: tb/tb_select_in.sv
// Scoreboard bench for select_in: per-channel expected-item queues filled on
// accepted enqueues and checked against the channel head when dequeued.
module tb_select_in;
  localparam int FW = 8;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic nRST;
  int   n_pass = 0;
  int   n_total = 0;

  logic [W-1:0] sb [FW][$];
  logic [3:0]   m_idx;

  select_in_if #(.funnelWidth(FW), .width(W)) bus ();

  select_in #(.funnelWidth(FW), .width(W)) dut (
    .CLK  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic m_rdy(input logic [FW-1:0] deq);
    int k;
    k = int'(m_idx);
    if (k >= FW) return 1'b0;
    return (sb[k].size() == 0) || deq[k];
  endfunction

  function automatic logic [FW-1:0] m_full();
    logic [FW-1:0] f;
    for (int i = 0; i < FW; i++) f[i] = (sb[i].size() != 0);
    return f;
  endfunction

  function automatic logic [W-1:0] head(input int ch);
    return bus.out_first[ch*W +: W];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < FW; i++) sb[i].delete();
    m_idx = '0;
  endtask

  task automatic drive(input logic enq, input logic [W-1:0] d, input logic sel,
                       input logic [31:0] sv, input logic [FW-1:0] deq);
    bus.enq_ena     = enq;
    bus.enq_v       = d;
    bus.select_ena  = sel;
    bus.select_v    = sv;
    bus.out_deq_ena = deq;
    #1;
  endtask

  // Apply the driven inputs to the model, then clock the DUT.
  task automatic commit();
    logic fire;
    int   k;
    fire = bus.enq_ena && m_rdy(bus.out_deq_ena);
    k    = int'(m_idx);
    for (int i = 0; i < FW; i++)
      if (bus.out_deq_ena[i] && sb[i].size() > 0) void'(sb[i].pop_front());
    if (fire) sb[k].push_back(bus.enq_v);
    if (bus.select_ena) m_idx = bus.select_v[3:0];
    @(posedge clk);
    #1;
    bus.enq_ena     = 1'b0;
    bus.select_ena  = 1'b0;
    bus.out_deq_ena = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b1, 16'hDEAD, 1'b1, 32'd3, 8'hFF);
    @(posedge clk);
    #1;
    model_clear();
    n_total++; if (bus.enq_rdy !== 1'b1) $display("FAIL reset_enq_rdy got %b exp 1", bus.enq_rdy); else n_pass++;
    n_total++; if (bus.out_first_rdy !== 8'h00) $display("FAIL reset_first_rdy got %h exp 00", bus.out_first_rdy); else n_pass++;
    n_total++; if (bus.out_deq_rdy !== 8'h00) $display("FAIL reset_deq_rdy got %h exp 00", bus.out_deq_rdy); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.select_rdy !== 1'b1) $display("FAIL reset_select_rdy got %b exp 1", bus.select_rdy); else n_pass++;
    n_total++; if (bus.out_first !== '0) $display("FAIL reset_data got %h exp 0", bus.out_first); else n_pass++;
    nRST = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_basic();
    drive(1'b1, 16'h1234, 1'b0, '0, '0);
    n_total++; if (bus.enq_rdy !== 1'b1) $display("FAIL basic_enq_rdy got %b exp 1", bus.enq_rdy); else n_pass++;
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h01) $display("FAIL basic_first_rdy got %h exp 01", bus.out_first_rdy); else n_pass++;
    n_total++; if (head(0) !== 16'h1234) $display("FAIL basic_data got %h exp 1234", head(0)); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", bus.busy); else n_pass++;
    drive(1'b1, 16'h5678, 1'b0, '0, '0);
    n_total++; if (bus.enq_rdy !== 1'b0) $display("FAIL basic_full_rdy got %b exp 0", bus.enq_rdy); else n_pass++;
    commit();
    n_total++; if (head(0) !== sb[0][0]) $display("FAIL basic_unchanged got %h exp %h", head(0), sb[0][0]); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h01);
    commit();
    n_total++; if (bus.out_first_rdy !== m_full()) $display("FAIL basic_drain got %h exp %h", bus.out_first_rdy, m_full()); else n_pass++;
  endtask

  task automatic test_select();
    drive(1'b0, '0, 1'b1, 32'd5, '0);
    commit();
    drive(1'b1, 16'hBEEF, 1'b0, '0, '0);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h20) $display("FAIL sel_first_rdy got %h exp 20", bus.out_first_rdy); else n_pass++;
    n_total++; if (head(5) !== 16'hBEEF) $display("FAIL sel_data got %h exp beef", head(5)); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h20);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h00) $display("FAIL sel_deq_rdy got %h exp 00", bus.out_first_rdy); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL sel_deq_busy got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_refill();
    drive(1'b0, '0, 1'b1, 32'd3, '0);
    commit();
    drive(1'b1, 16'h0001, 1'b0, '0, '0);
    commit();
    drive(1'b1, 16'h0002, 1'b0, '0, 8'h08);
    n_total++; if (bus.enq_rdy !== 1'b1) $display("FAIL refill_enq_rdy got %b exp 1", bus.enq_rdy); else n_pass++;
    n_total++; if (head(3) !== sb[3][0]) $display("FAIL refill_old got %h exp %h", head(3), sb[3][0]); else n_pass++;
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h08) $display("FAIL refill_full got %h exp 08", bus.out_first_rdy); else n_pass++;
    n_total++; if (head(3) !== 16'h0002) $display("FAIL refill_data got %h exp 0002", head(3)); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h08);
    commit();
  endtask

  task automatic test_select_enq_same();
    drive(1'b0, '0, 1'b1, 32'd2, '0);
    commit();
    drive(1'b1, 16'hAAAA, 1'b1, 32'd6, '0);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h04) $display("FAIL same_old_idx got %h exp 04", bus.out_first_rdy); else n_pass++;
    n_total++; if (head(2) !== 16'hAAAA) $display("FAIL same_data2 got %h exp aaaa", head(2)); else n_pass++;
    drive(1'b1, 16'h5555, 1'b0, '0, '0);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h44) $display("FAIL same_new_idx got %h exp 44", bus.out_first_rdy); else n_pass++;
    n_total++; if (head(6) !== 16'h5555) $display("FAIL same_data6 got %h exp 5555", head(6)); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h44);
    commit();
  endtask

  task automatic test_oob();
    drive(1'b0, '0, 1'b1, 32'hFFFF_FFF9, '0);
    commit();
    drive(1'b1, 16'h1111, 1'b0, '0, '0);
    n_total++; if (bus.enq_rdy !== 1'b0) $display("FAIL oob_enq_rdy got %b exp 0", bus.enq_rdy); else n_pass++;
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h00) $display("FAIL oob_first_rdy got %h exp 00", bus.out_first_rdy); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h02);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h00) $display("FAIL oob_empty_deq got %h exp 00", bus.out_first_rdy); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL oob_busy got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 32'd0, '0);
    commit();
    for (int k = 0; k < FW; k++) begin
      drive(1'b1, W'(16'hC000 + k), 1'b1, 32'(k + 1), '0);
      commit();
    end
    n_total++; if (bus.out_first_rdy !== 8'hFF) $display("FAIL fill_all got %h exp ff", bus.out_first_rdy); else n_pass++;
    for (int k = 0; k < FW; k++) begin
      n_total++; if (head(k) !== sb[k][0]) $display("FAIL fill_data ch%0d got %h exp %h", k, head(k), sb[k][0]); else n_pass++;
    end
    nRST = 1'b0;
    drive(1'b1, 16'h7777, 1'b1, 32'd4, 8'h0F);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    model_clear();
    drive(1'b0, '0, 1'b0, '0, '0);
    n_total++; if (bus.out_first_rdy !== 8'h00) $display("FAIL mid_reset_rdy got %h exp 00", bus.out_first_rdy); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", bus.busy); else n_pass++;
    drive(1'b1, 16'h00AB, 1'b0, '0, '0);
    commit();
    n_total++; if (bus.out_first_rdy !== 8'h01) $display("FAIL mid_reset_idx got %h exp 01", bus.out_first_rdy); else n_pass++;
    drive(1'b0, '0, 1'b0, '0, 8'h01);
    commit();
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] deq;
    logic          exp_rdy;
    for (int c = 0; c < 400; c++) begin
      deq = FW'($urandom);
      drive(1'($urandom), W'($urandom), ($urandom_range(0, 3) == 0),
            {28'($urandom), 4'($urandom_range(0, 9))}, deq);
      exp_rdy = m_rdy(deq);
      n_total++; if (bus.enq_rdy !== exp_rdy) $display("FAIL b2b_enq_rdy cyc%0d got %b exp %b", c, bus.enq_rdy, exp_rdy); else n_pass++;
      for (int i = 0; i < FW; i++) begin
        if (deq[i] && sb[i].size() > 0) begin
          n_total++; if (head(i) !== sb[i][0]) $display("FAIL b2b_data cyc%0d ch%0d got %h exp %h", c, i, head(i), sb[i][0]); else n_pass++;
        end
      end
      commit();
      n_total++; if (bus.out_first_rdy !== m_full()) $display("FAIL b2b_full cyc%0d got %h exp %h", c, bus.out_first_rdy, m_full()); else n_pass++;
      n_total++; if (bus.busy !== (|m_full())) $display("FAIL b2b_busy cyc%0d got %b exp %b", c, bus.busy, |m_full()); else n_pass++;
    end
  endtask

  initial begin
    nRST = 1'b1;
    bus.enq_ena     = 1'b0;
    bus.enq_v       = '0;
    bus.select_ena  = 1'b0;
    bus.select_v    = '0;
    bus.out_deq_ena = '0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_select();
    test_refill();
    test_select_enq_same();
    test_oob();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
